// File: rtl/leaf_pkt_pkg.sv
// Shared field layout, control opcodes and state encoding for the BFT leaf packet interface.
package leaf_pkt_pkg;

  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 4;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int NUM_BRAM_ADDR_BITS    = 7;
  localparam int FREESPACE_UPDATE_SIZE = 64;
  localparam int CREDIT_BITS           = NUM_BRAM_ADDR_BITS + 1;

  localparam int VALID_BIT = 48;
  localparam int LEAF_MSB  = 47;
  localparam int LEAF_LSB  = 44;
  localparam int PORT_MSB  = 43;
  localparam int PORT_LSB  = 40;
  localparam int ADDR_MSB  = 39;
  localparam int ADDR_LSB  = 33;
  localparam int CTRL_BIT  = 32;

  // Sub-fields inside the payload of a control packet
  localparam int OP_MSB       = 31;
  localparam int OP_LSB       = 30;
  localparam int CFG_LEAF_LSB = 8;
  localparam int CFG_PORT_LSB = 4;

  localparam logic [1:0] OP_CONFIG = 2'b01;
  localparam logic [1:0] OP_CREDIT = 2'b10;

  localparam logic [CREDIT_BITS-1:0] MAX_CREDITS = CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  function automatic logic [PACKET_BITS-1:0] pack_data(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    return {1'b1, leaf, port, addr, 1'b0, payload};
  endfunction

endpackage

// File: rtl/leaf_pkt_ctrl_decode.sv
// Combinational decode of config / credit-return control packets arriving from the BFT.
module leaf_pkt_ctrl_decode
  import leaf_pkt_pkg::*;
(
  input  logic [PACKET_BITS-1:0]   din_i,
  output logic                     is_config_o,
  output logic                     is_credit_o,
  output logic [NUM_LEAF_BITS-1:0] cfg_leaf_o,
  output logic [NUM_PORT_BITS-1:0] cfg_port_o
);

  logic       ctrl_vld;
  logic [1:0] opcode;
  logic       unused_bits;

  assign ctrl_vld    = din_i[VALID_BIT] & din_i[CTRL_BIT];
  assign opcode      = din_i[OP_MSB:OP_LSB];
  assign is_config_o = ctrl_vld && (opcode == OP_CONFIG);
  assign is_credit_o = ctrl_vld && (opcode == OP_CREDIT);
  assign cfg_leaf_o  = din_i[CFG_LEAF_LSB +: NUM_LEAF_BITS];
  assign cfg_port_o  = din_i[CFG_PORT_LSB +: NUM_PORT_BITS];

  // Routing header and the rest of the payload carry nothing for the transmit side
  assign unused_bits = ^{din_i[LEAF_MSB:ADDR_LSB], din_i[OP_LSB-1:CFG_LEAF_LSB+NUM_LEAF_BITS],
                         din_i[CFG_PORT_LSB-1:0]};

endmodule

// File: rtl/leaf_packet_tx.sv
// BFT leaf transmit port: AXI-stream to 49-bit data packets with credit flow control, 1-cycle latency.
// Optional per-destination packet counter on pkt_count when LEAF_PACKET_TX_STATS_EN is defined.
module leaf_packet_tx
  import leaf_pkt_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
  input  logic [PAYLOAD_BITS-1:0] s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic                    configured,
  output logic [CREDIT_BITS-1:0]  credits
`ifdef LEAF_PACKET_TX_STATS_EN
  ,
  output logic [31:0]             pkt_count
`endif
);

  state_t                   state_q, state_d;
  logic [CREDIT_BITS-1:0]   credits_q, credits_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [NUM_LEAF_BITS-1:0] leaf_q, leaf_d;
  logic [NUM_PORT_BITS-1:0] port_q, port_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [CREDIT_BITS:0]     credit_sum;

  logic                     is_config, is_credit, send;
  logic [NUM_LEAF_BITS-1:0] cfg_leaf;
  logic [NUM_PORT_BITS-1:0] cfg_port;

  leaf_pkt_ctrl_decode u_decode (
    .din_i       (din_leaf_bft2interface),
    .is_config_o (is_config),
    .is_credit_o (is_credit),
    .cfg_leaf_o  (cfg_leaf),
    .cfg_port_o  (cfg_port)
  );

  assign s_tready   = (state_q == ST_RUN) && (credits_q != '0);
  assign send       = s_tvalid && s_tready;
  assign configured = (state_q != ST_UNCFG);
  assign credits    = credits_q;
  assign dout_leaf_interface2bft = dout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_UNCFG;
      credits_q <= MAX_CREDITS;
      addr_q    <= '0;
      leaf_q    <= '0;
      port_q    <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      addr_q    <= addr_d;
      leaf_q    <= leaf_d;
      port_q    <= port_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    leaf_d     = leaf_q;
    port_d     = port_q;
    addr_d     = addr_q;
    dout_d     = '0;
    credit_sum = {1'b0, credits_q} - {{CREDIT_BITS{1'b0}}, send}
               + (is_credit ? (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE) : '0);
    credits_d  = (credit_sum > {1'b0, MAX_CREDITS}) ? MAX_CREDITS : credit_sum[CREDIT_BITS-1:0];

    // The outgoing packet always uses the destination/addr held before this cycle
    if (send) begin
      dout_d = pack_data(leaf_q, port_q, addr_q, s_tdata);
      addr_d = addr_q + 1'b1;
    end

    if (is_config) begin
      leaf_d    = cfg_leaf;
      port_d    = cfg_port;
      addr_d    = '0;
      credits_d = MAX_CREDITS;
    end

    case (state_q)
      ST_UNCFG: state_d = ST_UNCFG;
      ST_RUN:   if (credits_d == '0) state_d = ST_STALL;
      ST_STALL: if (credits_d != '0) state_d = ST_RUN;
      default:  state_d = ST_UNCFG;
    endcase
    if (is_config) state_d = ST_RUN;
  end

`ifdef LEAF_PACKET_TX_STATS_EN
  logic [31:0] pkt_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_q <= '0;
    end else if (is_config) begin
      pkt_count_q <= '0;
    end else if (send) begin
      pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_leaf_packet_tx.sv
// Directed self-checking bench for leaf_packet_tx; inputs change and outputs are sampled on the falling edge.
module tb_leaf_packet_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [48:0] din = '0;
  logic [48:0] dout;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        configured;
  logic [7:0]  credits;
`ifdef LEAF_PACKET_TX_STATS_EN
  logic [31:0] pkt_count;
`endif

  int passed = 0;
  int total  = 0;

  localparam logic [48:0] CFG35        = {1'b1, 4'h0, 4'h0, 7'h00, 1'b1, 32'h4000_0350};
  localparam logic [48:0] CFG35_NOCTRL = {1'b1, 4'h0, 4'h0, 7'h00, 1'b0, 32'h4000_0350};
  localparam logic [48:0] CFG72        = {1'b1, 4'h0, 4'h0, 7'h00, 1'b1, 32'h4000_0720};
  localparam logic [48:0] CRED         = {1'b1, 4'h0, 4'h0, 7'h00, 1'b1, 32'h8000_0000};

  leaf_packet_tx dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_bft2interface  (din),
    .dout_leaf_interface2bft (dout),
    .s_tdata                 (tdata),
    .s_tvalid                (tvalid),
    .s_tready                (tready),
    .configured              (configured),
    .credits                 (credits)
`ifdef LEAF_PACKET_TX_STATS_EN
    ,
    .pkt_count               (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [48:0] pkt(input logic [3:0] l, input logic [3:0] p,
                                      input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, 1'b0, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    #1 reset = 1'b1;
    #1;
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_tready", 64'(tready), 64'h0);
    chk("rst_configured", 64'(configured), 64'h0);
    chk("rst_credits", 64'(credits), 64'd128);
    @(negedge clk);
    reset = 1'b0;

    // Unconfigured: valid data and a ctrl=0 look-alike config must both be ignored
    tdata  = 32'hDEAD_BEEF;
    tvalid = 1'b1;
    din    = CFG35_NOCTRL;
    for (int i = 0; i < 20; i++) begin
      tick();
      din = '0;
      chk("uncfg_tready", 64'(tready), 64'h0);
      chk("uncfg_dout", 64'(dout), 64'h0);
    end
    chk("uncfg_configured", 64'(configured), 64'h0);

    // Configure leaf 3 / port 5
    tvalid = 1'b0;
    din    = CFG35;
    tick();
    din = '0;
    chk("cfg_configured", 64'(configured), 64'h1);
    chk("cfg_credits", 64'(credits), 64'd128);
    chk("cfg_tready", 64'(tready), 64'h1);

    for (int i = 0; i < 4; i++) begin
      tdata  = 32'hA0 + i;
      tvalid = 1'b1;
      tick();
      chk("stream4_dout", 64'(dout), 64'(pkt(4'd3, 4'd5, 7'(i), 32'hA0 + i)));
    end
    tvalid = 1'b0;
    tick();
    chk("idle_dout", 64'(dout), 64'h0);
    chk("stream4_credits", 64'(credits), 64'd124);
`ifdef LEAF_PACKET_TX_STATS_EN
    chk("stream4_pkt_count", 64'(pkt_count), 64'd4);
`endif

    // Re-arm, then drain all 128 credits back-to-back
    din = CFG35;
    tick();
    din = '0;
    chk("rearm_credits", 64'(credits), 64'd128);
    for (int i = 0; i < 128; i++) begin
      tdata  = 32'h100 + i;
      tvalid = 1'b1;
      if (i == 127) chk("last_credit_tready", 64'(tready), 64'h1);
      tick();
      chk("drain_dout", 64'(dout), 64'(pkt(4'd3, 4'd5, 7'(i), 32'h100 + i)));
    end
    chk("drained_credits", 64'(credits), 64'd0);
    chk("drained_tready", 64'(tready), 64'h0);
    tick();
    chk("stall_no_send", 64'(dout), 64'h0);
    din = CRED;
    tick();
    din = '0;
    chk("credit_ret_credits", 64'(credits), 64'd64);
    chk("credit_ret_tready", 64'(tready), 64'h1);
    chk("credit_ret_dout", 64'(dout), 64'h0);
    tdata = 32'hBEEF;
    tick();
    chk("wrap_dout", 64'(dout), 64'(pkt(4'd3, 4'd5, 7'd0, 32'hBEEF)));
    chk("wrap_credits", 64'(credits), 64'd63);
    tvalid = 1'b0;

    // Credit return coincident with a send at credits=100 saturates at 128
    din = CFG35;
    tick();
    din = '0;
    tvalid = 1'b1;
    for (int i = 0; i < 28; i++) begin
      tdata = 32'h200 + i;
      tick();
    end
    chk("pre_sat_credits", 64'(credits), 64'd100);
    tdata = 32'h300;
    din   = CRED;
    tick();
    din = '0;
    chk("sat_credits", 64'(credits), 64'd128);
    chk("sat_dout", 64'(dout), 64'(pkt(4'd3, 4'd5, 7'd28, 32'h300)));

    // Reconfigure to leaf 7 / port 2 mid-stream
    tdata = 32'h301;
    tick();
    tdata = 32'h302;
    tick();
    chk("pre_recfg_credits", 64'(credits), 64'd126);
    tdata = 32'h303;
    din   = CFG72;
    tick();
    din = '0;
    chk("recfg_old_dest_dout", 64'(dout), 64'(pkt(4'd3, 4'd5, 7'd31, 32'h303)));
    chk("recfg_credits", 64'(credits), 64'd128);
    tdata = 32'h304;
    tick();
    chk("recfg_new_dest_dout", 64'(dout), 64'(pkt(4'd7, 4'd2, 7'd0, 32'h304)));
    chk("recfg_post_credits", 64'(credits), 64'd127);
`ifdef LEAF_PACKET_TX_STATS_EN
    chk("recfg_pkt_count", 64'(pkt_count), 64'd1);
`endif

    // Asynchronous reset mid-burst
    tdata = 32'h305;
    tick();
    chk("preburst_dout", 64'(dout), 64'(pkt(4'd7, 4'd2, 7'd1, 32'h305)));
    #2 reset = 1'b1;
    #1;
    chk("arst_dout", 64'(dout), 64'h0);
    chk("arst_tready", 64'(tready), 64'h0);
    chk("arst_configured", 64'(configured), 64'h0);
    chk("arst_credits", 64'(credits), 64'd128);
`ifdef LEAF_PACKET_TX_STATS_EN
    chk("arst_pkt_count", 64'(pkt_count), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("post_arst_dout", 64'(dout), 64'h0);
    chk("post_arst_tready", 64'(tready), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
